apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Shares one APB master port among NUM_REQ on-chip requesters (DMA, CPU bridge, debug).
//  Round-robin arbitration picks one requester at a time. The block then runs the APB SETUP/ACCESS
//  sequence and decodes the 4 one-hot slave selects from the address.
//  It applies a pready timeout and returns rdata/slverr to the winner with a one-cycle done pulse.
//  Sits between the requesters and the APB slaves 0..3.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  ADDR_W      32  address width
//  DATA_W      32  data width; strobe width = DATA_W/8
//  SEL_LSB     12  slave index = paddr[SEL_LSB+1:SEL_LSB] -> psel one-hot of 4
//  TIMEOUT     16  max ACCESS cycles without pready before forced error; 0 = no timeout
// PORTS
//  pclk        in   1               clock, all logic on rising edge
//  preset      in   1               synchronous reset, active-high
//  req         in   NUM_REQ         per-requester request level; held until its done
//  req_addr    in   NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
//  req_write   in   NUM_REQ         1 = write
//  req_wdata   in   NUM_REQ*DATA_W  write data
//  req_strb    in   NUM_REQ*DATA_W/8 byte strobes (forced 0 on reads)
//  req_prot    in   NUM_REQ*3       pprot value
//  gnt         out  NUM_REQ         one-hot owner, high SETUP through ACCESS
//  done        out  NUM_REQ         one-cycle pulse to owner on completion
//  rsp_rdata   out  DATA_W          read data, valid with done
//  rsp_err     out  1               slverr or timeout, valid with done
//  psel        out  4               one-hot slave select
//  penable     out  1               APB enable
//  paddr       out  ADDR_W          APB address
//  pwrite      out  1               APB direction
//  pwdata      out  DATA_W          APB write data
//  pstrb       out  DATA_W/8        APB strobes
//  pprot       out  3               APB protection
//  prdata      in   DATA_W          slave read data
//  pready      in   1               slave ready
//  pslverr     in   1               slave error
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, timeout counter 0; every output 0.
//  - Reset mid-transfer abandons the transfer: no done pulse; psel/penable drop next cycle.
//  - Timing: IDLE->SETUP->ACCESS.
//    - IDLE: on any req, latch winner's addr/write/wdata/strb/prot into APB regs; set gnt, psel; go SETUP.
//    - SETUP: one cycle, psel high, penable 0; go ACCESS.
//    - ACCESS: penable 1. APB outputs stay stable until completion.
//  - Completion = ACCESS && pready, or ACCESS && timeout counter reaching TIMEOUT.
//    - At that edge: done[owner]<=1 for one cycle.
//    - rsp_rdata <= prdata on reads, 0 on writes.
//    - rsp_err <= pslverr on normal completion; rsp_err <= 1 on timeout.
//    - penable<=0. rr pointer <= owner+1 (mod NUM_REQ).
//  - Latency: req high in cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done in cycle 3 (zero wait).
//    Each wait state adds 1.
//  - Back-to-back: at the completion edge, arbitrate req with the current owner masked.
//    - If any remain: go directly to SETUP (psel per new address, penable 0, new gnt).
//    - If none remain: go IDLE with psel=0.
//  - The owner may re-request from the cycle after done.
//  - Round-robin: search starts at pointer, wraps at NUM_REQ-1 -> 0. The lowest index at or after the pointer wins.
//  - A requester dropping req while granted is ignored: the transfer completes and done still pulses.
//  - Timeout counter: clears on entry to ACCESS and counts each ACCESS cycle with pready=0.
//    Width $clog2(TIMEOUT+1). TIMEOUT=0 disables the timeout.
//  - pslverr is sampled only when pready=1. prdata is ignored on writes.
// STRUCTURE
//  - Shared header apb_defs.vh:
//    - state encodings IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2;
//    - APB_SEL_W=4;
//    - pprot constants.
//  - Sub-module apb_rr_picker: combinational masked round-robin select.
//    Inputs req, mask, pointer; outputs one-hot winner and index. Instantiated once.
//  - Top level: FSM, APB output registers, slave decode, timeout counter, response registers.
// TESTING
//  1. Single write:
//     - Stimulus: req[0] with addr 0x0000_0004, wdata 0xDEADBEEF, strb 4'hF; pready=1.
//     - Expected: SETUP with psel=0001, penable=0; next cycle penable=1; done[0] in cycle 3; rsp_err=0.
//  2. Read with wait:
//     - Stimulus: req[1] read at addr 0x0000_1008; pready low 3 ACCESS cycles, then pready=1 with prdata 0xCAFEBABE.
//     - Expected: psel=0010; paddr stable throughout; done[1] with rsp_rdata=0xCAFEBABE 6 cycles after req.
//  3. Fairness:
//     - Stimulus: req=4'b1111 held continuously.
//     - Expected: grants 0,1,2,3,0; back-to-back SETUP on each completion edge, no IDLE gap.
//  4. Timeout:
//     - Stimulus: TIMEOUT=16; req[2] at addr 0x0000_200C; pready stuck 0.
//     - Expected: completion after 16 ACCESS cycles; done[2] with rsp_err=1; psel=0100 then drops.
//  5. Slave error and partial strobe:
//     - Stimulus: req[3] write at 0x0000_3010, strb 4'b1010; pslverr=1 with pready.
//     - Expected: psel=1000, pstrb=1010; rsp_err=1.
//  6. Reset mid-ACCESS:
//     - Stimulus: assert preset during ACCESS.
//     - Expected: next cycle all outputs 0, no done; after release, req[2] wins first (pointer=0, req=4'b0100).

Source files
------------

// File: rtl/apb_req_arbiter_pkg.sv
// apb_req_arbiter_pkg: shared FSM encoding, APB select width, pprot bits and slave decode
package apb_req_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;
  typedef enum logic [2:0] {PPROT_PRIV = 3'b001, PPROT_NSEC = 3'b010, PPROT_INSTR = 3'b100} pprot_bit_e;
  localparam int APB_SEL_W = 4;
  function automatic logic [APB_SEL_W-1:0] sel_decode(input logic [1:0] idx);
    sel_decode = APB_SEL_W'(1) << idx;
  endfunction
endpackage

// File: rtl/apb_req_arbiter_picker.sv
// apb_req_arbiter_picker: combinational masked round-robin select, first eligible at or after ptr
module apb_req_arbiter_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0] cand;
  logic found;
  always_comb begin
    elig = req_i & ~mask_i;
    any_o = |elig;
    idx_o = '0;
    cand = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    win_o = any_o ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin share of one APB master port with slave decode and pready timeout
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                        pclk_i,
  input  logic                        preset_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb_i,
  input  logic [NUM_REQ*3-1:0]        req_prot_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [APB_SEL_W-1:0]        psel_o,
  output logic                        penable_o,
  output logic [ADDR_W-1:0]           paddr_o,
  output logic                        pwrite_o,
  output logic [DATA_W-1:0]           pwdata_o,
  output logic [DATA_W/8-1:0]         pstrb_o,
  output logic [2:0]                  pprot_o,
  input  logic [DATA_W-1:0]           prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_W / 8;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_e state_q;
  logic [IW-1:0] owner_q, ptr_q, ptr_d, nxt_ptr, win_idx;
  logic [NUM_REQ-1:0] gnt_q, done_q, win, mask;
  logic [TW-1:0] cnt_q;
  logic [APB_SEL_W-1:0] psel_q;
  logic [ADDR_W-1:0] paddr_q, win_addr;
  logic [DATA_W-1:0] pwdata_q, rdata_q;
  logic [SW-1:0] pstrb_q;
  logic [2:0] pprot_q;
  logic penable_q, pwrite_q, err_q, any, tmo, cmp, arb;
  // completion edge re-arbitrates from owner+1 with the owner masked, giving back-to-back SETUP
  always_comb begin
    tmo = TIMEOUT != 0 && !pready_i && cnt_q == TW'(TIMEOUT - 1);
    cmp = state_q == ACCESS && (pready_i || tmo);
    nxt_ptr = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    ptr_d = cmp ? nxt_ptr : ptr_q;
    mask = state_q == ACCESS ? gnt_q : '0;
    arb = state_q == IDLE || cmp;
  end
  apb_req_arbiter_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i (req_i),
    .mask_i(mask),
    .ptr_i (ptr_d),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (any)
  );
  assign win_addr = req_addr_i[win_idx*ADDR_W +: ADDR_W];
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      cnt_q <= '0;
      psel_q <= '0;
      penable_q <= 1'b0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      pprot_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      done_q <= cmp ? gnt_q : '0;
      if (cmp) begin
        rdata_q <= pwrite_q ? '0 : prdata_i;
        err_q <= pready_i ? pslverr_i : 1'b1;
        ptr_q <= ptr_d;
      end
      if (arb) begin
        state_q <= any ? SETUP : IDLE;
        gnt_q <= win;
        owner_q <= win_idx;
        psel_q <= any ? sel_decode(win_addr[SEL_LSB +: 2]) : '0;
        penable_q <= 1'b0;
      end
      if (arb && any) begin
        paddr_q <= win_addr;
        pwrite_q <= req_write_i[win_idx];
        pwdata_q <= req_wdata_i[win_idx*DATA_W +: DATA_W];
        pstrb_q <= req_write_i[win_idx] ? req_strb_i[win_idx*SW +: SW] : '0;
        pprot_q <= req_prot_i[win_idx*3 +: 3];
      end
      if (state_q == SETUP) begin
        state_q <= ACCESS;
        penable_q <= 1'b1;
        cnt_q <= '0;
      end else if (state_q == ACCESS && !cmp) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign gnt_o = gnt_q;
  assign done_o = done_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o = err_q;
  assign psel_o = psel_q;
  assign penable_o = penable_q;
  assign paddr_o = paddr_q;
  assign pwrite_o = pwrite_q;
  assign pwdata_o = pwdata_q;
  assign pstrb_o = pstrb_q;
  assign pprot_o = pprot_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scenario tasks with hand-computed expectations
module tb_apb_req_arbiter;
  import apb_req_arbiter_pkg::*;
  logic pclk, preset;
  logic [3:0] req, req_write, gnt, done, psel, pstrb;
  logic [127:0] req_addr, req_wdata;
  logic [15:0] req_strb;
  logic [11:0] req_prot;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic rsp_err, penable, pwrite, pready, pslverr;
  logic [2:0] pprot;
  int checks = 0;
  int failures = 0;
  apb_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .SEL_LSB(12), .TIMEOUT(16)) dut (
    .pclk_i(pclk), .preset_i(preset), .req_i(req), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .req_prot_i(req_prot), .gnt_o(gnt), .done_o(done), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .psel_o(psel), .penable_o(penable), .paddr_o(paddr),
    .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge pclk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    req_addr[i*32 +: 32] = a;
    req_write[i] = w;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4] = s;
    req_prot[i*3 +: 3] = p;
  endtask
  task automatic test_reset;
    preset = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick; tick;
    checks++; if ({gnt, done, psel, penable} !== 13'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", {gnt, done, psel, penable}); end
    checks++; if ({paddr, pwdata, pwrite, pstrb, pprot} !== 72'h0) begin failures++; $display("FAIL rst_apb got=%h exp=0", {paddr, pwdata, pwrite, pstrb, pprot}); end
    checks++; if ({rsp_rdata, rsp_err} !== 33'h0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {rsp_rdata, rsp_err}); end
    preset = 1'b0;
  endtask
  task automatic test_single_write;
    set_req(0, 32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, PPROT_PRIV);
    req = 4'b0001; pready = 1'b1;
    tick;
    checks++; if ({gnt, psel, penable} !== {4'b0001, 4'b0001, 1'b0}) begin failures++; $display("FAIL wr_setup got gnt=%b psel=%b pen=%b exp 0001 0001 0", gnt, psel, penable); end
    checks++; if ({paddr, pwdata, pwrite, pstrb, pprot} !== {32'h4, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b001}) begin failures++; $display("FAIL wr_apb got=%h/%h/%b/%h/%b exp 4/deadbeef/1/f/001", paddr, pwdata, pwrite, pstrb, pprot); end
    tick;
    checks++; if ({psel, penable, done} !== {4'b0001, 1'b1, 4'b0000}) begin failures++; $display("FAIL wr_access got psel=%b pen=%b done=%b exp 0001 1 0000", psel, penable, done); end
    tick;
    checks++; if ({done, rsp_err, rsp_rdata} !== {4'b0001, 1'b0, 32'h0}) begin failures++; $display("FAIL wr_done got done=%b err=%b rdata=%h exp 0001 0 0", done, rsp_err, rsp_rdata); end
    checks++; if ({gnt, psel, penable} !== 9'h0) begin failures++; $display("FAIL wr_idle got gnt=%b psel=%b pen=%b exp 0", gnt, psel, penable); end
    req = 4'b0000;
    tick;
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL wr_done_pulse got=%b exp=0000", done); end
  endtask
  task automatic test_read_wait;
    set_req(1, 32'h0000_1008, 1'b0, 32'h1111_1111, 4'hF, PPROT_NSEC);
    req = 4'b0010; pready = 1'b0;
    tick;
    checks++; if ({gnt, psel, penable, pwrite, pstrb} !== {4'b0010, 4'b0010, 1'b0, 1'b0, 4'h0}) begin failures++; $display("FAIL rd_setup got gnt=%b psel=%b pen=%b wr=%b strb=%h", gnt, psel, penable, pwrite, pstrb); end
    for (int c = 2; c <= 5; c++) begin
      tick;
      checks++; if ({penable, paddr, done} !== {1'b1, 32'h0000_1008, 4'b0000}) begin failures++; $display("FAIL rd_wait%0d got pen=%b addr=%h done=%b exp 1 00001008 0000", c, penable, paddr, done); end
    end
    pready = 1'b1; prdata = 32'hCAFE_BABE;
    tick;
    checks++; if ({done, rsp_rdata, rsp_err} !== {4'b0010, 32'hCAFE_BABE, 1'b0}) begin failures++; $display("FAIL rd_done got done=%b rdata=%h err=%b exp 0010 cafebabe 0", done, rsp_rdata, rsp_err); end
    req = 4'b0000; pready = 1'b0; prdata = '0;
  endtask
  task automatic test_fairness;
    logic [3:0] e;
    logic [3:0] ed;
    preset = 1'b1;
    tick;
    preset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i) << 12, 1'b1, 32'(i), 4'hF, 3'b000);
    req = 4'b1111; pready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      ed = k == 0 ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
      tick;
      checks++; if ({gnt, psel, penable, done} !== {e, e, 1'b0, ed}) begin failures++; $display("FAIL rr_setup%0d got gnt=%b psel=%b pen=%b done=%b exp %b %b 0 %b", k, gnt, psel, penable, done, e, e, ed); end
      if (k == 4) req = 4'b0000;
      tick;
      checks++; if ({gnt, penable} !== {e, 1'b1}) begin failures++; $display("FAIL rr_access%0d got gnt=%b pen=%b exp %b 1", k, gnt, penable, e); end
    end
    tick;
    checks++; if ({done, gnt, psel} !== {4'b0001, 8'h0}) begin failures++; $display("FAIL rr_end got done=%b gnt=%b psel=%b exp 0001 0000 0000", done, gnt, psel); end
  endtask
  task automatic test_timeout;
    set_req(2, 32'h0000_200C, 1'b0, 32'h0, 4'hF, 3'b000);
    req = 4'b0100; pready = 1'b0;
    tick;
    checks++; if ({gnt, psel} !== {4'b0100, 4'b0100}) begin failures++; $display("FAIL to_setup got gnt=%b psel=%b exp 0100 0100", gnt, psel); end
    for (int c = 2; c <= 17; c++) begin
      tick;
      checks++; if ({penable, psel, done} !== {1'b1, 4'b0100, 4'b0000}) begin failures++; $display("FAIL to_wait%0d got pen=%b psel=%b done=%b exp 1 0100 0000", c, penable, psel, done); end
    end
    tick;
    checks++; if ({done, rsp_err, psel, penable} !== {4'b0100, 1'b1, 4'b0000, 1'b0}) begin failures++; $display("FAIL to_done got done=%b err=%b psel=%b pen=%b exp 0100 1 0000 0", done, rsp_err, psel, penable); end
    req = 4'b0000;
  endtask
  task automatic test_slverr_strobe;
    set_req(3, 32'h0000_3010, 1'b1, 32'h1234_5678, 4'b1010, PPROT_INSTR);
    req = 4'b1000; pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    tick;
    checks++; if ({gnt, psel, pstrb, pprot} !== {4'b1000, 4'b1000, 4'b1010, 3'b100}) begin failures++; $display("FAIL se_setup got gnt=%b psel=%b strb=%b prot=%b exp 1000 1000 1010 100", gnt, psel, pstrb, pprot); end
    tick;
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL se_access got pen=%b exp 1", penable); end
    tick;
    checks++; if ({done, rsp_err, rsp_rdata} !== {4'b1000, 1'b1, 32'h0}) begin failures++; $display("FAIL se_done got done=%b err=%b rdata=%h exp 1000 1 0", done, rsp_err, rsp_rdata); end
    req = 4'b0000; pslverr = 1'b0; prdata = '0; pready = 1'b0;
  endtask
  task automatic test_reset_mid;
    set_req(1, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
    set_req(2, 32'h0000_2000, 1'b1, 32'h5555_AAAA, 4'hF, 3'b000);
    req = 4'b0010; pready = 1'b0;
    tick;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rm_setup got gnt=%b exp 0010", gnt); end
    tick;
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rm_access got pen=%b exp 1", penable); end
    preset = 1'b1; pready = 1'b1;
    tick;
    checks++; if ({gnt, done, psel, penable, paddr} !== 45'h0) begin failures++; $display("FAIL rm_reset got gnt=%b done=%b psel=%b pen=%b addr=%h exp 0", gnt, done, psel, penable, paddr); end
    preset = 1'b0; pready = 1'b0; req = 4'b0100;
    tick;
    checks++; if ({done, gnt, psel} !== {4'b0000, 4'b0100, 4'b0100}) begin failures++; $display("FAIL rm_after got done=%b gnt=%b psel=%b exp 0000 0100 0100", done, gnt, psel); end
    pready = 1'b1;
    tick; tick;
    checks++; if ({done, rsp_err} !== {4'b0100, 1'b0}) begin failures++; $display("FAIL rm_done got done=%b err=%b exp 0100 0", done, rsp_err); end
    req = 4'b0000; pready = 1'b0;
  endtask
  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_fairness;
    test_timeout;
    test_slverr_strobe;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
